add4_operand_loader: RTL and testbench
======================================

# add4_operand_loader

Upstream operand-collection stage for the `add4` four-operand adder. It accepts 4-bit operands one at a time over a valid/ready handshake and assembles them into the `a`, `b`, `c`, `d` word set. It then presents the full set to `add4` with an output valid/ready handshake, holding the set stable until it is consumed. It also keeps a wrap-around count of completed transactions for bench and debug visibility.

## Interface
- `WIDTH`, default 4: width of each operand; `add4` requires 4.
- `CNT_W`, default 8: width of the transaction counter.

- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `in_data`  input  WIDTH  operand value offered by the producer.
- `in_valid`  input  1  producer has an operand on `in_data`.
- `in_ready`  output  1  loader accepts an operand this cycle.
- `abort`  input  1  discard the current set and restart collection.
- `a`, `b`, `c`, `d`  output  WIDTH each  operand set to `add4`, in load order a→b→c→d.
- `out_valid`  output  1  a complete operand set is present on `a`..`d`.
- `out_ready`  input  1  consumer takes the set this cycle.
- `op_idx`  output  2  index of the next operand slot to fill (0=a … 3=d).
- `txn_cnt`  output  CNT_W  number of completed output transfers, modulo 2^CNT_W.

## Operation
- FSM has two states: COLLECT and PRESENT. Reset state is COLLECT.
- Outputs are decoded from state:
  - `in_ready` = (state==COLLECT).
  - `out_valid` = (state==PRESENT).
- Input transfer occurs on an edge where `in_valid && in_ready && !abort`:
  - `in_data` is written to the slot selected by `op_idx`.
  - `op_idx` increments.
  - On the transfer with `op_idx`==3, `op_idx` wraps to 0 and the state goes to PRESENT.
- In PRESENT:
  - `in_ready`=0 and `in_valid` is ignored.
  - `a`..`d` hold steady.
- Output transfer occurs on an edge where `out_valid && out_ready && !abort`:
  - `txn_cnt` increments, wrapping from 2^CNT_W−1 to 0.
  - The state goes to COLLECT.
  - `a`..`d` keep their old values until overwritten by new input transfers.
- `abort` takes effect on an edge in either state:
  - The state goes to COLLECT and `op_idx` goes to 0.
  - `a`..`d` are cleared to 0.
  - `txn_cnt` is unchanged.
  - `abort` has priority over a simultaneous input or output transfer: that transfer does not happen and no counter increments.
- Reset has priority over `abort` and over both handshakes.
- Data is stored and forwarded unchanged. No arithmetic is applied to operands.
- Producer rule: once `in_valid` is raised it is held, with stable `in_data`, until accepted. The loader does not rely on this rule for correctness.

## Timing
- Reset values, visible after the first rising edge with `rst`=1:
  - state=COLLECT, `in_ready`=1, `out_valid`=0, `op_idx`=0, `a`=`b`=`c`=`d`=0, `txn_cnt`=0.
- Reset asserted in mid-collection or during PRESENT returns the block to these values on the next edge. Any partial set is lost.
- Throughput: one operand per cycle while in COLLECT.
- Latency: if the 4th operand is accepted at edge N, `out_valid`=1 and `d` is valid immediately after edge N. Minimum is 4 cycles from the first operand to `out_valid`.
- If `out_ready` is high at edge N+1, the transfer completes at edge N+1 and `in_ready`=1 after it. The minimum period is therefore 5 cycles per set, with no back-to-back overlap.
- `out_ready` may be held high in advance. It has no effect while `out_valid`=0.
- `a`..`d` change only on input-transfer, abort, or reset edges. They never change while `out_valid`=1, except on an abort or reset edge.

## Test plan
- Reset, then feed 3, 5, 7, 9 back-to-back with `out_ready`=0:
  - After the 4th edge: `a`=3, `b`=5, `c`=7, `d`=9, `out_valid`=1, `in_ready`=0.
  - Held unchanged for 10 cycles; `in_valid` pulses with `in_data`=15 during this time are ignored.
- From the held state, raise `out_ready` for 1 cycle:
  - `txn_cnt` goes 0→1, `out_valid`=0, `in_ready`=1, `op_idx`=0.
  - Feed 15, 15, 15, 15: the `add4` DUT shows `sum`=12, `ov`=1.
- Feed 1 and 2, then `abort` on the same edge as `in_valid` with 4:
  - Result: `op_idx`=0, `a`..`d`=0, 4 is not captured.
  - Then feed 4, 4, 4, 4: `a`..`d`=4, `out_valid`=1.
- In PRESENT, assert `abort` and `out_ready` together:
  - `out_valid`=0 and `txn_cnt` does not increment.
- Complete 256 transfers with CNT_W=8 and `$random` 4-bit operands:
  - `txn_cnt` reads 0 afterwards.
  - Every set matches the reference queue of loaded values, and every `add4` result equals the modulo sum plus the overflow flag.
- Assert `rst` for 1 cycle after operand 2 of a set:
  - All outputs return to their reset values.
  - The next 4 operands form a fresh set.

Source files
------------

// File: rtl/add4_operand_loader_if.sv
// Operand-loader bus: producer-side operand handshake and consumer-side operand-set handshake.
// The loader sits on the slave modport; the environment driving it uses master.
interface add4_operand_loader_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, a, b, c, d, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, a, b, c, d, out_valid
  );
endinterface

// File: rtl/add4_operand_loader.sv
// Collects four operands one per cycle and presents them as an a/b/c/d set to add4,
// holding the set until it is taken; counts completed output transfers.
module add4_operand_loader #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  add4_operand_loader_if.slave bus,
  output logic [1:0]         op_idx,
  output logic [CNT_W-1:0]   txn_cnt
);

  // state   | meaning
  // COLLECT | accepting operands into slot op_idx
  // PRESENT | full set on a..d, waiting for out_ready
  typedef enum logic {COLLECT, PRESENT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] slot_q [4];
  logic             in_xfer, out_xfer;
  logic             in_ready_int, out_valid_int;

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    in_xfer       = 1'b0;
    out_xfer      = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready_int = 1'b1;
        in_xfer      = bus.in_valid && !abort;
        if (in_xfer && op_idx == 2'd3) state_d = PRESENT;
      end
      PRESENT: begin
        out_valid_int = 1'b1;
        out_xfer      = bus.out_ready && !abort;
        if (out_xfer) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    if (abort) state_d = COLLECT;
  end

  // Abort wipes the partial or presented set; the transaction count survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_idx  <= '0;
      txn_cnt <= '0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
    end else if (abort) begin
      op_idx <= '0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
    end else begin
      if (in_xfer) begin
        slot_q[op_idx] <= bus.in_data;
        op_idx         <= op_idx + 2'd1;
      end
      if (out_xfer) txn_cnt <= txn_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.a         = slot_q[0];
  assign bus.b         = slot_q[1];
  assign bus.c         = slot_q[2];
  assign bus.d         = slot_q[3];

endmodule

// File: tb/tb_add4_operand_loader.sv
// Directed bench for add4_operand_loader: handshakes, abort, reset and counter wrap,
// with hand-computed expected operand sets and add4 sums.
module tb_add4_operand_loader;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             abort;
  logic [1:0]       op_idx;
  logic [CNT_W-1:0] txn_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  add4_operand_loader_if #(.WIDTH(WIDTH)) bus ();

  add4_operand_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .abort   (abort),
    .bus     (bus.slave),
    .op_idx  (op_idx),
    .txn_cnt (txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] abcd();
    return {bus.a, bus.b, bus.c, bus.d};
  endfunction

  // add4 view of the presented set: {ov, sum}
  function automatic logic [4:0] add4_of_dut();
    return {1'b0, bus.a} + {1'b0, bus.b} + {1'b0, bus.c} + {1'b0, bus.d};
  endfunction

  task automatic feed(input logic [3:0] v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic feed4(input logic [3:0] v0, input logic [3:0] v1,
                       input logic [3:0] v2, input logic [3:0] v3);
    feed(v0); feed(v1); feed(v2); feed(v3);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_op_idx"},    op_idx,        0);
    check({tag, "_abcd"},      abcd(),        16'h0000);
    check({tag, "_txn_cnt"},   txn_cnt,       0);
  endtask

  initial begin
    logic [3:0] v [4];
    logic [4:0] exp_sum;

    rst = 1'b1; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    check_reset_state("reset");

    // First set, held with out_ready low while in_valid pulses are ignored
    feed(4'd3);
    check("op_idx_after_1", op_idx, 1);
    feed(4'd5); feed(4'd7); feed(4'd9);
    check("set1_abcd",      abcd(),        16'h3579);
    check("set1_out_valid", bus.out_valid, 1);
    check("set1_in_ready",  bus.in_ready,  0);
    check("set1_op_idx",    op_idx,        0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 4'd15;
      step();
      check("hold_abcd",      abcd(),        16'h3579);
      check("hold_out_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    check("hold_txn_cnt", txn_cnt, 0);

    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("xfer1_txn_cnt",   txn_cnt,       1);
    check("xfer1_out_valid", bus.out_valid, 0);
    check("xfer1_in_ready",  bus.in_ready,  1);
    check("xfer1_op_idx",    op_idx,        0);
    check("xfer1_abcd_kept", abcd(),        16'h3579);

    // 15+15+15+15 = 60 -> sum 12 with overflow
    feed4(4'd15, 4'd15, 4'd15, 4'd15);
    check("set2_abcd", abcd(),        16'hFFFF);
    check("set2_add4", add4_of_dut(), {1'b1, 4'd12});
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("xfer2_txn_cnt", txn_cnt, 2);

    // Abort in collection beats a simultaneous input transfer
    feed(4'd1); feed(4'd2);
    check("pre_abort_op_idx", op_idx, 2);
    abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 4'd4;
    step();
    abort = 1'b0; bus.in_valid = 1'b0;
    check("abort_op_idx",  op_idx,       0);
    check("abort_abcd",    abcd(),       16'h0000);
    check("abort_in_rdy",  bus.in_ready, 1);
    feed4(4'd4, 4'd4, 4'd4, 4'd4);
    check("set3_abcd",      abcd(),        16'h4444);
    check("set3_out_valid", bus.out_valid, 1);

    // Abort in PRESENT beats a simultaneous output transfer
    abort = 1'b1; bus.out_ready = 1'b1;
    step();
    abort = 1'b0; bus.out_ready = 1'b0;
    check("abort_p_out_valid", bus.out_valid, 0);
    check("abort_p_txn_cnt",   txn_cnt,       2);
    check("abort_p_abcd",      abcd(),        16'h0000);
    check("abort_p_in_ready",  bus.in_ready,  1);

    // 256 random sets from reset with out_ready held high: counter wraps to 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_txn_cnt", txn_cnt, 0);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 256; t++) begin
      for (int k = 0; k < 4; k++) v[k] = 4'($urandom_range(15));
      exp_sum = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]} + {1'b0, v[3]};
      feed4(v[0], v[1], v[2], v[3]);
      check("rand_out_valid", bus.out_valid, 1);
      check("rand_abcd",      abcd(),        {v[0], v[1], v[2], v[3]});
      check("rand_add4",      add4_of_dut(), exp_sum);
      step();
      check("rand_xfer_done", bus.out_valid, 0);
    end
    bus.out_ready = 1'b0;
    check("wrap_txn_cnt", txn_cnt, 0);

    // Reset in mid-collection drops the partial set
    feed(4'd10); feed(4'd11);
    check("pre_rst_op_idx", op_idx, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("mid_rst");
    feed4(4'd6, 4'd7, 4'd8, 4'd9);
    check("fresh_abcd",      abcd(),        16'h6789);
    check("fresh_out_valid", bus.out_valid, 1);
    check("fresh_txn_cnt",   txn_cnt,       0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
